regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl_if.sv | 41 ++++
 rtl/regfile_wb_ctrl.sv | 168 ++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_ctrl_if.sv
// Handshake and query bus between the ALU / load pipeline, the issue-stage hazard
// check and the register-file write-back controller.
interface regfile_wb_ctrl_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_ret_valid;
  logic [31:0] ld_ret_data;
  logic        ld_ret_ready;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wb_en;
  logic [4:0]  rd_index;
  logic [31:0] wb_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue_valid, ld_issue_rd,
    input  ld_ret_valid, ld_ret_data,
    input  rs1_index, rs2_index,
    output alu_ready, ld_issue_ready, ld_ret_ready,
    output rs1_busy, rs2_busy,
    output wb_en, rd_index, wb_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue_valid, ld_issue_rd,
    output ld_ret_valid, ld_ret_data,
    output rs1_index, rs2_index,
    input  alu_ready, ld_issue_ready, ld_ret_ready,
    input  rs1_busy, rs2_busy,
    input  wb_en, rd_index, wb_data
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back arbiter: merges in-order load returns with a small ALU
// result queue into one registered write port, and reports load-pending hazards.
module regfile_wb_ctrl #(
  parameter int ALU_DEPTH = 2,
  parameter int LD_DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);
  localparam int AP_W = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;
  localparam int AC_W = $clog2(ALU_DEPTH + 1);
  localparam int LP_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int LC_W = $clog2(LD_DEPTH + 1);
  localparam logic [AP_W-1:0] A_LAST = AP_W'(ALU_DEPTH - 1);
  localparam logic [AC_W-1:0] A_FULL = AC_W'(ALU_DEPTH);
  localparam logic [LP_W-1:0] L_LAST = LP_W'(LD_DEPTH - 1);
  localparam logic [LC_W-1:0] L_FULL = LC_W'(LD_DEPTH);

  logic [4:0]      alu_rd_q   [ALU_DEPTH];
  logic [4:0]      alu_rd_d   [ALU_DEPTH];
  logic [31:0]     alu_data_q [ALU_DEPTH];
  logic [31:0]     alu_data_d [ALU_DEPTH];
  logic [AP_W-1:0] alu_head_q, alu_head_d, alu_tail_q, alu_tail_d;
  logic [AC_W-1:0] alu_cnt_q, alu_cnt_d;

  logic [4:0]      ld_rd_q  [LD_DEPTH];
  logic [4:0]      ld_rd_d  [LD_DEPTH];
  logic            ld_vld_q [LD_DEPTH];
  logic            ld_vld_d [LD_DEPTH];
  logic [LP_W-1:0] ld_head_q, ld_head_d, ld_tail_q, ld_tail_d;
  logic [LC_W-1:0] ld_cnt_q, ld_cnt_d;

  logic            wb_en_q, wb_en_d;
  logic            wb_load_q, wb_load_d;
  logic [4:0]      rd_index_q, rd_index_d;
  logic [31:0]     wb_data_q, wb_data_d;

  logic alu_full, alu_fire, iss_fire, ret_fire;
  logic alu_bypass, alu_push, alu_pop;
  logic rs1_hit, rs2_hit;

  assign alu_full           = (alu_cnt_q == A_FULL);
  assign bus.alu_ready      = !rst || !alu_full;
  assign bus.ld_issue_ready = !rst || (ld_cnt_q != L_FULL);
  // Returns stall while the ALU queue is full so ALU results cannot starve.
  assign bus.ld_ret_ready   = rst && (ld_cnt_q != '0) && !alu_full;

  assign alu_fire = bus.alu_valid && bus.alu_ready;
  assign iss_fire = bus.ld_issue_valid && bus.ld_issue_ready;
  assign ret_fire = bus.ld_ret_valid && bus.ld_ret_ready;

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (ld_vld_q[i] && (ld_rd_q[i] == bus.rs1_index)) rs1_hit = 1'b1;
      if (ld_vld_q[i] && (ld_rd_q[i] == bus.rs2_index)) rs2_hit = 1'b1;
    end
    if (wb_en_q && wb_load_q && (rd_index_q == bus.rs1_index)) rs1_hit = 1'b1;
    if (wb_en_q && wb_load_q && (rd_index_q == bus.rs2_index)) rs2_hit = 1'b1;
  end

  assign bus.rs1_busy = rst && (bus.rs1_index != 5'd0) && rs1_hit;
  assign bus.rs2_busy = rst && (bus.rs2_index != 5'd0) && rs2_hit;

  always_comb begin
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    alu_head_d = alu_head_q;
    alu_tail_d = alu_tail_q;
    alu_cnt_d  = alu_cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_vld_d   = ld_vld_q;
    ld_head_d  = ld_head_q;
    ld_tail_d  = ld_tail_q;
    ld_cnt_d   = ld_cnt_q;
    wb_en_d    = 1'b0;
    wb_load_d  = 1'b0;
    rd_index_d = rd_index_q;
    wb_data_d  = wb_data_q;
    alu_bypass = 1'b0;
    alu_pop    = 1'b0;

    // Load return beats queued ALU results, which beat a direct ALU bypass.
    if (ret_fire) begin
      wb_en_d    = (ld_rd_q[ld_head_q] != 5'd0);
      wb_load_d  = 1'b1;
      rd_index_d = ld_rd_q[ld_head_q];
      wb_data_d  = bus.ld_ret_data;
    end else if (alu_cnt_q != '0) begin
      wb_en_d    = 1'b1;
      rd_index_d = alu_rd_q[alu_head_q];
      wb_data_d  = alu_data_q[alu_head_q];
      alu_pop    = 1'b1;
    end else if (alu_fire && (bus.alu_rd != 5'd0)) begin
      wb_en_d    = 1'b1;
      rd_index_d = bus.alu_rd;
      wb_data_d  = bus.alu_data;
      alu_bypass = 1'b1;
    end

    alu_push = alu_fire && (bus.alu_rd != 5'd0) && !alu_bypass;

    if (alu_pop) alu_head_d = (alu_head_q == A_LAST) ? '0 : alu_head_q + AP_W'(1);
    if (alu_push) begin
      alu_rd_d[alu_tail_q]   = bus.alu_rd;
      alu_data_d[alu_tail_q] = bus.alu_data;
      alu_tail_d = (alu_tail_q == A_LAST) ? '0 : alu_tail_q + AP_W'(1);
    end
    if (alu_push && !alu_pop) alu_cnt_d = alu_cnt_q + AC_W'(1);
    else if (!alu_push && alu_pop) alu_cnt_d = alu_cnt_q - AC_W'(1);

    if (ret_fire) begin
      ld_vld_d[ld_head_q] = 1'b0;
      ld_head_d = (ld_head_q == L_LAST) ? '0 : ld_head_q + LP_W'(1);
    end
    if (iss_fire) begin
      ld_vld_d[ld_tail_q] = 1'b1;
      ld_rd_d[ld_tail_q]  = bus.ld_issue_rd;
      ld_tail_d = (ld_tail_q == L_LAST) ? '0 : ld_tail_q + LP_W'(1);
    end
    if (iss_fire && !ret_fire) ld_cnt_d = ld_cnt_q + LC_W'(1);
    else if (!iss_fire && ret_fire) ld_cnt_d = ld_cnt_q - LC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ALU_DEPTH; i++) begin
        alu_rd_q[i]   <= '0;
        alu_data_q[i] <= '0;
      end
      for (int i = 0; i < LD_DEPTH; i++) begin
        ld_rd_q[i]  <= '0;
        ld_vld_q[i] <= 1'b0;
      end
      alu_head_q <= '0;
      alu_tail_q <= '0;
      alu_cnt_q  <= '0;
      ld_head_q  <= '0;
      ld_tail_q  <= '0;
      ld_cnt_q   <= '0;
      wb_en_q    <= 1'b0;
      wb_load_q  <= 1'b0;
      rd_index_q <= '0;
      wb_data_q  <= '0;
    end else begin
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      alu_head_q <= alu_head_d;
      alu_tail_q <= alu_tail_d;
      alu_cnt_q  <= alu_cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_vld_q   <= ld_vld_d;
      ld_head_q  <= ld_head_d;
      ld_tail_q  <= ld_tail_d;
      ld_cnt_q   <= ld_cnt_d;
      wb_en_q    <= wb_en_d;
      wb_load_q  <= wb_load_d;
      rd_index_q <= rd_index_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.wb_en    = wb_en_q;
  assign bus.rd_index = rd_index_q;
  assign bus.wb_data  = wb_data_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: hand-derived vector table, corner-case sequences and
// randomized traffic compared against a queue-level reference model.
module tb_regfile_wb_ctrl;
  localparam int ALU_DEPTH = 2;
  localparam int LD_DEPTH  = 4;
  localparam int RAND_CYCLES = 3000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl #(.ALU_DEPTH(ALU_DEPTH), .LD_DEPTH(LD_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected just before and just after the edge.
  typedef struct {
    logic        rst;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        ret_v;
    logic [31:0] ret_d;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_alu_rdy;
    logic        e_iss_rdy;
    logic        e_ret_rdy;
    logic        e_b1;
    logic        e_b2;
    logic        e_wb;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } alu_ent_t;

  alu_ent_t    m_alu[$];
  logic [4:0]  m_ld[$];
  logic        m_wb;
  logic        m_wbl;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  vec_t tbl[21];

  function automatic vec_t mkv(input int r, input int av, input int ard, input logic [31:0] adat,
                               input int iv, input int ird, input int rv, input logic [31:0] rdat,
                               input int s1, input int s2, input int ea, input int ei, input int er,
                               input int eb1, input int eb2, input int ew, input int erd,
                               input logic [31:0] edat);
    vec_t v;
    v.rst = 1'(r);       v.alu_v = 1'(av);     v.alu_rd = 5'(ard);  v.alu_d = adat;
    v.iss_v = 1'(iv);    v.iss_rd = 5'(ird);   v.ret_v = 1'(rv);    v.ret_d = rdat;
    v.rs1 = 5'(s1);      v.rs2 = 5'(s2);
    v.e_alu_rdy = 1'(ea); v.e_iss_rdy = 1'(ei); v.e_ret_rdy = 1'(er);
    v.e_b1 = 1'(eb1);    v.e_b2 = 1'(eb2);
    v.e_wb = 1'(ew);     v.e_rd = 5'(erd);     v.e_data = edat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst                = v.rst;
    bus.alu_valid      = v.alu_v;
    bus.alu_rd         = v.alu_rd;
    bus.alu_data       = v.alu_d;
    bus.ld_issue_valid = v.iss_v;
    bus.ld_issue_rd    = v.iss_rd;
    bus.ld_ret_valid   = v.ret_v;
    bus.ld_ret_data    = v.ret_d;
    bus.rs1_index      = v.rs1;
    bus.rs2_index      = v.rs2;
  endtask

  task automatic runVec(input string tag, input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput({tag, " alu_ready"},      32'(bus.alu_ready),      32'(v.e_alu_rdy));
    checkOutput({tag, " ld_issue_ready"}, 32'(bus.ld_issue_ready), 32'(v.e_iss_rdy));
    checkOutput({tag, " ld_ret_ready"},   32'(bus.ld_ret_ready),   32'(v.e_ret_rdy));
    checkOutput({tag, " rs1_busy"},       32'(bus.rs1_busy),       32'(v.e_b1));
    checkOutput({tag, " rs2_busy"},       32'(bus.rs2_busy),       32'(v.e_b2));
    @(posedge clk);
    #1;
    checkOutput({tag, " wb_en"}, 32'(bus.wb_en), 32'(v.e_wb));
    if (v.e_wb || !v.rst) begin
      checkOutput({tag, " rd_index"}, 32'(bus.rd_index), 32'(v.e_rd));
      checkOutput({tag, " wb_data"},  bus.wb_data,       v.e_data);
    end
  endtask

  function automatic logic mBusy(input logic r, input logic [4:0] idx);
    if (!r || idx == 5'd0) return 1'b0;
    foreach (m_ld[i]) if (m_ld[i] == idx) return 1'b1;
    return m_wb && m_wbl && (m_rd == idx);
  endfunction

  // Reference model: queues of pending work; one write per cycle chosen by fixed priority.
  task automatic modelCycle(input vec_t vin, output vec_t vout);
    logic alu_rdy, iss_rdy, ret_rdy, bypass;
    logic [4:0] head;
    alu_ent_t e;
    vout = vin;
    alu_rdy = !vin.rst || (m_alu.size() < ALU_DEPTH);
    iss_rdy = !vin.rst || (m_ld.size() < LD_DEPTH);
    ret_rdy = vin.rst && (m_ld.size() > 0) && (m_alu.size() < ALU_DEPTH);
    vout.e_alu_rdy = alu_rdy;
    vout.e_iss_rdy = iss_rdy;
    vout.e_ret_rdy = ret_rdy;
    vout.e_b1 = mBusy(vin.rst, vin.rs1);
    vout.e_b2 = mBusy(vin.rst, vin.rs2);
    if (!vin.rst) begin
      m_alu.delete();
      m_ld.delete();
      m_wb = 1'b0; m_wbl = 1'b0; m_rd = 5'd0; m_data = 32'd0;
    end else begin
      bypass = 1'b0;
      m_wb = 1'b0;
      m_wbl = 1'b0;
      if (vin.ret_v && ret_rdy) begin
        head = m_ld.pop_front();
        m_wb = (head != 5'd0); m_wbl = 1'b1; m_rd = head; m_data = vin.ret_d;
      end else if (m_alu.size() > 0) begin
        e = m_alu.pop_front();
        m_wb = 1'b1; m_rd = e.rd; m_data = e.data;
      end else if (vin.alu_v && alu_rdy && vin.alu_rd != 5'd0) begin
        bypass = 1'b1;
        m_wb = 1'b1; m_rd = vin.alu_rd; m_data = vin.alu_d;
      end
      if (vin.alu_v && alu_rdy && vin.alu_rd != 5'd0 && !bypass) begin
        e.rd = vin.alu_rd;
        e.data = vin.alu_d;
        m_alu.push_back(e);
      end
      if (vin.iss_v && iss_rdy) m_ld.push_back(vin.iss_rd);
    end
    vout.e_wb = m_wb;
    vout.e_rd = m_rd;
    vout.e_data = m_data;
  endtask

  // Fields: rst, alu v/rd/data, issue v/rd, ret v/data, rs1, rs2 | alu_rdy, iss_rdy, ret_rdy, busy1, busy2, wb_en, rd, data
  task automatic fillTable();
    tbl[0]  = mkv(0, 0,0,0,             0,0, 0,0,             0,0, 1,1,0,0,0, 0,0,0);
    tbl[1]  = mkv(0, 1,5,32'h55,        1,6, 0,0,             6,0, 1,1,0,0,0, 0,0,0);
    tbl[2]  = mkv(1, 1,5,32'h1234,      0,0, 0,0,             5,0, 1,1,0,0,0, 1,5,32'h1234);
    tbl[3]  = mkv(1, 0,0,0,             0,0, 0,0,             5,0, 1,1,0,0,0, 0,0,0);
    tbl[4]  = mkv(1, 0,0,0,             1,7, 0,0,             7,0, 1,1,0,0,0, 0,0,0);
    tbl[5]  = mkv(1, 0,0,0,             0,0, 0,0,             7,0, 1,1,1,1,0, 0,0,0);
    tbl[6]  = mkv(1, 1,3,32'h33,        0,0, 1,32'hDEADBEEF,  7,3, 1,1,1,1,0, 1,7,32'hDEADBEEF);
    tbl[7]  = mkv(1, 0,0,0,             0,0, 0,0,             7,3, 1,1,0,1,0, 1,3,32'h33);
    tbl[8]  = mkv(1, 0,0,0,             0,0, 0,0,             7,3, 1,1,0,0,0, 0,0,0);
    tbl[9]  = mkv(1, 0,0,0,             1,0, 0,0,             0,0, 1,1,0,0,0, 0,0,0);
    tbl[10] = mkv(1, 0,0,0,             1,1, 0,0,             0,1, 1,1,1,0,0, 0,0,0);
    tbl[11] = mkv(1, 0,0,0,             1,2, 0,0,             1,2, 1,1,1,1,0, 0,0,0);
    tbl[12] = mkv(1, 0,0,0,             1,3, 0,0,             2,3, 1,1,1,1,0, 0,0,0);
    tbl[13] = mkv(1, 0,0,0,             1,4, 0,0,             3,4, 1,0,1,1,0, 0,0,0);
    tbl[14] = mkv(1, 0,0,0,             1,4, 1,32'hAAAA,      0,4, 1,0,1,0,0, 0,0,0);
    tbl[15] = mkv(1, 0,0,0,             0,0, 0,0,             1,4, 1,1,1,1,0, 0,0,0);
    tbl[16] = mkv(1, 0,0,0,             0,0, 1,32'h1111,      1,2, 1,1,1,1,1, 1,1,32'h1111);
    tbl[17] = mkv(1, 0,0,0,             0,0, 1,32'h2222,      1,2, 1,1,1,1,1, 1,2,32'h2222);
    tbl[18] = mkv(1, 0,0,0,             0,0, 1,32'h3333,      1,3, 1,1,1,0,1, 1,3,32'h3333);
    tbl[19] = mkv(1, 0,0,0,             0,0, 1,32'h4444,      3,0, 1,1,0,1,0, 0,0,0);
    tbl[20] = mkv(1, 0,0,0,             0,0, 0,0,             3,0, 1,1,0,0,0, 0,0,0);
  endtask

  // ALU queue fills while loads keep returning; a full queue must block the next return.
  task automatic seqStarvation();
    runVec("starve0", mkv(1, 0,0,0,          1,10, 0,0,        10,0,  1,1,0,0,0, 0,0,0));
    runVec("starve1", mkv(1, 0,0,0,          1,12, 0,0,        10,12, 1,1,1,1,0, 0,0,0));
    runVec("starve2", mkv(1, 1,11,32'hB1,    0,0,  1,32'hA0,   10,12, 1,1,1,1,1, 1,10,32'hA0));
    runVec("starve3", mkv(1, 1,13,32'hB3,    1,14, 1,32'hA2,   12,14, 1,1,1,1,0, 1,12,32'hA2));
    runVec("starve4", mkv(1, 1,15,32'hB5,    0,0,  1,32'hA4,   14,12, 0,1,0,1,1, 1,11,32'hB1));
    runVec("starve5", mkv(1, 0,0,0,          0,0,  1,32'hA4,   14,11, 1,1,1,1,0, 1,14,32'hA4));
    runVec("starve6", mkv(1, 0,0,0,          0,0,  0,0,        14,13, 1,1,0,1,0, 1,13,32'hB3));
    runVec("drop_x0", mkv(1, 1,0,32'h77,     0,0,  0,0,        14,0,  1,1,0,0,0, 0,0,0));
    runVec("drop_x0b", mkv(1, 0,0,0,         0,0,  0,0,        0,0,   1,1,0,0,0, 0,0,0));
  endtask

  task automatic seqScoreboard();
    runVec("sb0", mkv(1, 0,0,0, 1,9, 0,0,         9,0, 1,1,0,0,0, 0,0,0));
    runVec("sb1", mkv(1, 0,0,0, 1,9, 0,0,         9,0, 1,1,1,1,0, 0,0,0));
    runVec("sb2", mkv(1, 0,0,0, 0,0, 1,32'h91,    9,0, 1,1,1,1,0, 1,9,32'h91));
    runVec("sb3", mkv(1, 0,0,0, 0,0, 1,32'h92,    9,0, 1,1,1,1,0, 1,9,32'h92));
    runVec("sb4", mkv(1, 0,0,0, 0,0, 0,0,         9,0, 1,1,0,1,0, 0,0,0));
    runVec("sb5", mkv(1, 0,0,0, 0,0, 0,0,         9,0, 1,1,0,0,0, 0,0,0));
  endtask

  task automatic seqMidReset();
    runVec("mrst0", mkv(1, 0,0,0,        1,20, 0,0,       20,21, 1,1,0,0,0, 0,0,0));
    runVec("mrst1", mkv(1, 0,0,0,        1,21, 0,0,       20,21, 1,1,1,1,0, 0,0,0));
    runVec("mrst2", mkv(1, 0,0,0,        1,22, 0,0,       20,21, 1,1,1,1,1, 0,0,0));
    runVec("mrst3", mkv(0, 1,26,32'hC6,  0,0,  1,32'hCC,  20,22, 1,1,0,0,0, 0,0,0));
    runVec("mrst4", mkv(0, 0,0,0,        0,0,  0,0,       20,22, 1,1,0,0,0, 0,0,0));
    runVec("mrst5", mkv(1, 0,0,0,        0,0,  1,32'hCD,  20,22, 1,1,0,0,0, 0,0,0));
    runVec("mrst6", mkv(1, 0,0,0,        0,0,  0,0,       21,22, 1,1,0,0,0, 0,0,0));
    runVec("mrst7", mkv(1, 0,0,0,        0,0,  0,0,       21,20, 1,1,0,0,0, 0,0,0));
  endtask

  task automatic runRandom();
    vec_t v;
    vec_t ve;
    for (int n = 0; n < RAND_CYCLES; n++) begin
      v.rst    = (n == 0) ? 1'b0 : ($urandom_range(255) != 0);
      v.alu_v  = 1'($urandom_range(1));
      v.alu_rd = 5'($urandom_range(7));
      v.alu_d  = $urandom;
      v.iss_v  = 1'($urandom_range(1));
      v.iss_rd = 5'($urandom_range(7));
      v.ret_v  = 1'($urandom_range(1));
      v.ret_d  = $urandom;
      v.rs1    = 5'($urandom_range(7));
      v.rs2    = 5'($urandom_range(7));
      modelCycle(v, ve);
      runVec($sformatf("rand[%0d]", n), ve);
    end
  endtask

  initial begin
    fillTable();
    for (int i = 0; i < 21; i++) runVec($sformatf("tbl[%0d]", i), tbl[i]);
    seqStarvation();
    seqScoreboard();
    seqMidReset();
    runRandom();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
